// File: rtl/tilt_pkg.sv
// -----------------------------------------------------------------------------
// tilt_pkg
// Shared constants and types for the accelerometer tilt-to-movement block.
//   ZERO_G     : offset-binary code that represents 0 g on an axis
//   ACC_W      : width of the per-axis step accumulator
//   MAG_MAX    : largest tilt magnitude an axis reports
//   SAMPLE_W   : width of the raw accelerometer sample
//   TILT_W     : width of the signed tilt value (sample - ZERO_G)
//   MV_*       : bit positions inside the 4-bit movement vector
// -----------------------------------------------------------------------------
package tilt_pkg;

   localparam int ZERO_G   = 256;
   localparam int ACC_W    = 12;
   localparam int MAG_MAX  = 255;
   localparam int SAMPLE_W = 9;
   localparam int TILT_W   = 10;

   localparam int MV_RIGHT = 3;
   localparam int MV_LEFT  = 2;
   localparam int MV_DOWN  = 1;
   localparam int MV_UP    = 0;

   // Direction of the last non-idle tilt seen on an axis.
   typedef enum logic {
      SIGN_POS = 1'b0,
      SIGN_NEG = 1'b1
   } sign_e;

endpackage

// File: rtl/tilt_axis.sv
// -----------------------------------------------------------------------------
// tilt_axis
// One accelerometer axis: sample (or smoothing filter) register, tilt
// magnitude/sign, step accumulator and a registered pulse pair.
//
// Build option: TILT_SMOOTH_EN
//   defined   -> the sample register is a first-order IIR updated on tick
//   undefined -> the sample register simply captures accel on tick
//
// Ports
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   tick      : capture strobe, one cycle per sample period
//   eval      : tick delayed by one cycle; accumulator update strobe
//   enable    : low holds the accumulator at 0 and suppresses pulses
//   accel     : offset-binary acceleration, ZERO_G = 0 g
//   pulse_pos : one-cycle step toward positive tilt (right / down)
//   pulse_neg : one-cycle step toward negative tilt (left / up)
//   active    : tilt magnitude exceeded the dead zone at the last update
// -----------------------------------------------------------------------------
module tilt_axis
   import tilt_pkg::*;
#(
   parameter int unsigned DEADZONE    = 16,
   parameter int unsigned STEP_THRESH = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                eval,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] accel,
   output logic                pulse_pos,
   output logic                pulse_neg,
   output logic                active
);

   localparam logic [7:0]     DZ   = 8'(DEADZONE);
   localparam logic [ACC_W:0] STEP = (ACC_W+1)'(STEP_THRESH);
   localparam logic [ACC_W:0] SAT  = (ACC_W+1)'(2 * STEP_THRESH - 1);

   // ---------------------------------------------------------------- sample
   logic [SAMPLE_W-1:0] samp;
   logic [SAMPLE_W-1:0] samp_next;

`ifdef TILT_SMOOTH_EN
   // s + ((accel - s) >>> 2); the difference fits 10 bits signed, the sum
   // needs one more bit before it is clamped back into 0..511.
   logic signed [TILT_W-1:0] diff;
   logic signed [TILT_W-1:0] diff_sh;
   logic signed [TILT_W:0]   filt_sum;

   always_comb begin
      diff     = $signed({1'b0, accel}) - $signed({1'b0, samp});
      diff_sh  = diff >>> 2;
      filt_sum = $signed({2'b00, samp}) + $signed({diff_sh[TILT_W-1], diff_sh});
      if (filt_sum < 0) begin
         samp_next = '0;
      end else if (filt_sum > $signed(11'd511)) begin
         samp_next = '1;
      end else begin
         samp_next = filt_sum[SAMPLE_W-1:0];
      end
   end
`else
   assign samp_next = accel;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp <= SAMPLE_W'(ZERO_G);
      end else if (tick) begin
         samp <= samp_next;
      end
   end

   // ------------------------------------------------------ magnitude / sign
   logic [TILT_W-1:0] tilt;
   logic [TILT_W-1:0] tilt_abs;
   logic [7:0]        mag;
   logic [ACC_W:0]    excess;
   sign_e             sign_now;

   assign tilt     = {1'b0, samp} - TILT_W'(ZERO_G);
   // Two's-complement negate; -256 becomes +256 when read as unsigned.
   assign tilt_abs = tilt[TILT_W-1] ? (~tilt + 1'b1) : tilt;
   assign mag      = (tilt_abs > TILT_W'(MAG_MAX)) ? 8'(MAG_MAX) : tilt_abs[7:0];
   assign sign_now = tilt[TILT_W-1] ? SIGN_NEG : SIGN_POS;
   // Only meaningful when mag > DZ; the idle branch never uses it.
   assign excess   = {{(ACC_W-7){1'b0}}, 8'(mag - DZ)};

   // ---------------------------------------------------------- accumulator
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   sign_e            last_sign;
   sign_e            last_sign_next;
   logic             active_next;
   logic             pos_next;
   logic             neg_next;
   logic [ACC_W:0]   sum;

   always_comb begin
      acc_next       = acc;
      last_sign_next = last_sign;
      active_next    = active;
      pos_next       = 1'b0;
      neg_next       = 1'b0;
      sum            = '0;

      if (eval) begin
         if (!enable || (mag <= DZ)) begin
            acc_next    = '0;
            active_next = 1'b0;
         end else begin
            active_next = 1'b1;
            if (sign_now != last_sign) begin
               // Reversal restarts the accumulator and skips this step.
               // Clamping here keeps acc within 2*STEP-1 at all times.
               last_sign_next = sign_now;
               acc_next       = (excess > SAT) ? SAT[ACC_W-1:0] : excess[ACC_W-1:0];
            end else begin
               sum = {1'b0, acc} + excess;
               if (sum >= STEP) begin
                  sum = sum - STEP;
                  if (sign_now == SIGN_POS) begin
                     pos_next = 1'b1;
                  end else begin
                     neg_next = 1'b1;
                  end
               end
               if (sum > SAT) begin
                  sum = SAT;
               end
               acc_next = sum[ACC_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= '0;
         last_sign <= SIGN_POS;
         active    <= 1'b0;
         pulse_pos <= 1'b0;
         pulse_neg <= 1'b0;
      end else begin
         acc       <= acc_next;
         last_sign <= last_sign_next;
         active    <= active_next;
         pulse_pos <= pos_next;
         pulse_neg <= neg_next;
      end
   end

endmodule

// File: rtl/tilt_move_gen.sv
// -----------------------------------------------------------------------------
// tilt_move_gen
// Turns accelerometer tilt into one-cycle movement pulses for the ball stage.
// Steeper tilt beyond the dead zone produces steps at a higher rate.
//
// Build option: TILT_SMOOTH_EN (smooths each axis sample with an IIR filter;
// latency is the same with or without it).
//
// Pipeline: tick (cycle T) captures samples, eval (T+1) updates the
// accumulators, movement/active_* change at T+2.
//
// Ports
//   clk      : 100 MHz system clock
//   reset    : asynchronous active-low reset
//   enable   : high = generate motion; low = accumulators held at 0
//   accel_x  : X acceleration, offset binary, 256 = 0 g
//   accel_y  : Y acceleration, offset binary, 256 = 0 g
//   movement : one-cycle pulses {right, left, down, up}
//   active_x : X tilt beyond dead zone at the last update
//   active_y : Y tilt beyond dead zone at the last update
// -----------------------------------------------------------------------------
module tilt_move_gen
   import tilt_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned DEADZONE    = 16,
   parameter int unsigned STEP_THRESH = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] accel_x,
   input  logic [SAMPLE_W-1:0] accel_y,
   output logic [3:0]          movement,
   output logic                active_x,
   output logic                active_y
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // ---------------------------------------------------------- tick counter
   // Free-running regardless of enable; tick is registered so it rises
   // TICK_DIV cycles after reset is released.
   logic [CNT_W-1:0] tick_cnt;
   logic             wrap;
   logic             tick;
   logic             eval;

   assign wrap = (tick_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
         eval     <= 1'b0;
      end else begin
         tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
         tick     <= wrap;
         eval     <= tick;
      end
   end

   // ----------------------------------------------------------------- axes
   logic x_pos;
   logic x_neg;
   logic y_pos;
   logic y_neg;

   tilt_axis #(
      .DEADZONE    (DEADZONE),
      .STEP_THRESH (STEP_THRESH)
   ) u_axis_x (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .eval      (eval),
      .enable    (enable),
      .accel     (accel_x),
      .pulse_pos (x_pos),
      .pulse_neg (x_neg),
      .active    (active_x)
   );

   tilt_axis #(
      .DEADZONE    (DEADZONE),
      .STEP_THRESH (STEP_THRESH)
   ) u_axis_y (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .eval      (eval),
      .enable    (enable),
      .accel     (accel_y),
      .pulse_pos (y_pos),
      .pulse_neg (y_neg),
      .active    (active_y)
   );

   // Positive X tilt moves right, positive Y tilt moves down.
   always_comb begin
      movement           = '0;
      movement[MV_RIGHT] = x_pos;
      movement[MV_LEFT]  = x_neg;
      movement[MV_DOWN]  = y_pos;
      movement[MV_UP]    = y_neg;
   end

endmodule

// File: tb/tb_tilt_move_gen.sv
// -----------------------------------------------------------------------------
// tb_tilt_move_gen
// Self-checking bench for tilt_move_gen with TICK_DIV=10, DEADZONE=16,
// STEP_THRESH=64. A behavioural model predicts {movement, active_x, active_y}
// for every cycle; directed phases add literal pulse-count expectations.
// -----------------------------------------------------------------------------
module tb_tilt_move_gen;

   localparam int TICK_DIV    = 10;
   localparam int DEADZONE    = 16;
   localparam int STEP_THRESH = 64;
   localparam int ACC_SAT     = 2 * STEP_THRESH - 1;

   // ------------------------------------------------------ clock and reset
   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [8:0] accel_x;
   logic [8:0] accel_y;
   logic [3:0] movement;
   logic       active_x;
   logic       active_y;

   always #5 clk = ~clk;

   tilt_move_gen #(
      .TICK_DIV    (TICK_DIV),
      .DEADZONE    (DEADZONE),
      .STEP_THRESH (STEP_THRESH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .accel_x  (accel_x),
      .accel_y  (accel_y),
      .movement (movement),
      .active_x (active_x),
      .active_y (active_y)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Cycles since reset release: samples are taken on cycles n with
   // n % TICK_DIV == 0 (at the following edge), steps are decided one cycle
   // later, and the outputs become visible after that decision.
   int       m_n;
   int       m_samp [2];
   int       m_acc  [2];
   bit       m_neg  [2];
   bit       m_act  [2];
   logic [3:0] m_mov;
   bit       cap_pend;
   bit       eval_pend;
   logic [5:0] exp_q[$];

   function automatic int filter_step(input int s, input int a);
`ifdef TILT_SMOOTH_EN
      int t;
      t = s + ((a - s) >>> 2);
      if (t < 0) t = 0;
      if (t > 511) t = 511;
      return t;
`else
      return a;
`endif
   endfunction

   // Returns 1 for a positive step, -1 for a negative step, 0 for none.
   function automatic int axis_step(input int ax, input bit en);
      int tilt, mag, d;
      bit neg;
      tilt = m_samp[ax] - 256;
      mag  = (tilt < 0) ? -tilt : tilt;
      if (mag > 255) mag = 255;
      neg  = (tilt < 0);
      if (!en || mag <= DEADZONE) begin
         m_acc[ax] = 0;
         m_act[ax] = 0;
         return 0;
      end
      m_act[ax] = 1;
      d = mag - DEADZONE;
      if (neg != m_neg[ax]) begin
         m_neg[ax] = neg;
         m_acc[ax] = (d > ACC_SAT) ? ACC_SAT : d;
         return 0;
      end
      m_acc[ax] += d;
      axis_step = 0;
      if (m_acc[ax] >= STEP_THRESH) begin
         m_acc[ax] -= STEP_THRESH;
         axis_step = neg ? -1 : 1;
      end
      if (m_acc[ax] > ACC_SAT) m_acc[ax] = ACC_SAT;
   endfunction

   always @(posedge clk) begin
      int sx, sy;
      if (!reset) begin
         m_n       = 0;
         m_samp    = '{256, 256};
         m_acc     = '{0, 0};
         m_neg     = '{0, 0};
         m_act     = '{0, 0};
         m_mov     = '0;
         cap_pend  = 0;
         eval_pend = 0;
      end else begin
         m_n++;
         m_mov = '0;
         if (eval_pend) begin
            sx = axis_step(0, enable);
            sy = axis_step(1, enable);
            m_mov = {sx == 1, sx == -1, sy == 1, sy == -1};
            eval_pend = 0;
         end
         if (cap_pend) begin
            m_samp[0] = filter_step(m_samp[0], int'(accel_x));
            m_samp[1] = filter_step(m_samp[1], int'(accel_y));
            cap_pend  = 0;
            eval_pend = 1;
         end
         if (m_n % TICK_DIV == 0) cap_pend = 1;
      end
      exp_q.push_back({m_mov, m_act[0], m_act[1]});
   end

   // ------------------------------------------------------------ scoreboard
   int pulse_cnt [4];
   int dual_cnt;

   always @(negedge clk) begin
      logic [5:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!reset) e = '0;
         check("cycle_outputs", {26'd0, movement, active_x, active_y}, {26'd0, e});
      end
      if (reset) begin
         for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(movement[i]);
         if (movement == 4'b0110) dual_cnt++;
      end
   end

   // --------------------------------------------------------- driver tasks
   task automatic clear_counts();
      @(negedge clk);
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
      dual_cnt = 0;
   endtask

   task automatic set_accel(input int x, input int y);
      @(negedge clk);
      accel_x = 9'(x);
      accel_y = 9'(y);
   endtask

   task automatic run_ticks(input int n);
      repeat (n * TICK_DIV) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [8:0] rand_accel();
      case ($urandom_range(0, 3))
         0:       return 9'($urandom_range(236, 276));
         1:       return 9'($urandom_range(0, 511));
         2:       return ($urandom_range(0, 1) != 0) ? 9'd511 : 9'd0;
         default: return ($urandom_range(0, 1) != 0) ? 9'($urandom_range(300, 360))
                                                    : 9'($urandom_range(150, 212));
      endcase
   endfunction

   // ------------------------------------------------------------- stimulus
   initial begin
      int k;
      bit seen;
      reset    = 1'b0;
      enable   = 1'b1;
      accel_x  = 9'd256;
      accel_y  = 9'd256;
      dual_cnt = 0;
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

      #2;
      check("reset_movement", {28'd0, movement}, 32'd0);
      check("reset_active", {30'd0, active_x, active_y}, 32'd0);
      do_reset();

      // Dead zone: centred, then magnitude exactly at DEADZONE.
      clear_counts();
      run_ticks(5);
      set_accel(272, 256);
      run_ticks(50);
      check("deadzone_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
      check("deadzone_active_x", {31'd0, active_x}, 32'd0);

`ifndef TILT_SMOOTH_EN
      // Exact rate: excess 64 = STEP_THRESH -> one right step per tick.
      set_accel(336, 256);
      run_ticks(2);
      clear_counts();
      run_ticks(10);
      check("exact_rate_right", 32'(pulse_cnt[3]), 32'd10);
      check("exact_rate_others", 32'(pulse_cnt[2] + pulse_cnt[1] + pulse_cnt[0]), 32'd0);
      check("exact_rate_active_x", {31'd0, active_x}, 32'd1);

      // Half rate left, then reversal to half rate right.
      set_accel(208, 256);
      run_ticks(2);
      clear_counts();
      run_ticks(10);
      check("half_rate_left", 32'(pulse_cnt[2]), 32'd5);
      set_accel(304, 256);
      run_ticks(2);
      clear_counts();
      run_ticks(10);
      check("half_rate_right", 32'(pulse_cnt[3]), 32'd5);
      check("half_rate_no_left", 32'(pulse_cnt[2]), 32'd0);

      // Saturated tilt on both axes: left+down coincide every tick.
      set_accel(0, 511);
      run_ticks(2);
      clear_counts();
      run_ticks(10);
      check("saturate_dual", 32'(dual_cnt), 32'd10);
      check("saturate_right_up", 32'(pulse_cnt[3] + pulse_cnt[0]), 32'd0);
`endif

      // Enable low mid-run: no pulses, axes inactive.
      set_accel(0, 511);
      @(negedge clk);
      enable = 1'b0;
      clear_counts();
      run_ticks(4);
      check("disable_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
      check("disable_active", {30'd0, active_x, active_y}, 32'd0);
      @(negedge clk);
      enable = 1'b1;
      run_ticks(3);

      // Reset during the decision cycle drops the pending step.
      set_accel(336, 256);
      run_ticks(3);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while ((m_n % TICK_DIV != 1) && k < 4 * TICK_DIV);
      check("find_decision_cycle", 32'(m_n % TICK_DIV), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("reset_mid_outputs", {26'd0, movement, active_x, active_y}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      k = 0;
      seen = 0;
      while (!seen && k < 4 * TICK_DIV) begin
         @(posedge clk);
         #1;
         k++;
         seen = (movement != 4'b0000);
      end
`ifndef TILT_SMOOTH_EN
      // Tick 10 cycles after release, step visible two cycles later.
      check("first_step_latency", 32'(k), 32'd12);
`endif

`ifdef TILT_SMOOTH_EN
      // Smoothing step response from 256 toward 384.
      begin
         int exp_s [4] = '{288, 312, 330, 343};
         do_reset();
         set_accel(384, 256);
         for (int t = 0; t < 4; t++) begin
            k = 0;
            do begin
               @(posedge clk);
               #1;
               k++;
            end while ((m_n % TICK_DIV != 1) && k < 2 * TICK_DIV);
            check("smooth_sample", 32'(dut.u_axis_x.samp), 32'(exp_s[t]));
         end
      end
`endif

      // Randomized phase: inputs change at arbitrary times, enable toggles.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) accel_x = rand_accel();
         if ($urandom_range(0, 7) == 0) accel_y = rand_accel();
         if ($urandom_range(0, 63) == 0) enable = ~enable;
      end
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
